// File: rtl/sr04_echo_emulator.sv
// HC-SR04 responder: accepts a trig pulse and answers with an echo pulse whose
// width encodes a programmable distance, for loopback of the ranging chain.
module sr04_echo_emulator #(
    parameter int CLK_PER_US     = 100,
    parameter int TRIG_MIN_US    = 10,
    parameter int BURST_DELAY_US = 200,
    parameter int US_PER_CM      = 58,
    parameter int MAX_CM         = 400,
    parameter int TIMEOUT_US     = 38000,
    parameter int HOLDOFF_US     = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [9:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       trig_err,
    output logic       out_of_range
);

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        DELAY,
        ECHO,
        HOLDOFF
    } state_t;

    localparam int              PW           = $clog2(CLK_PER_US + 1);
    localparam logic [PW-1:0]   PRESC_MAX    = PW'(CLK_PER_US - 1);
    localparam logic [19:0]     TRIG_MIN_CYC = 20'(TRIG_MIN_US * CLK_PER_US);
    localparam logic [15:0]     BURST_L      = 16'(BURST_DELAY_US);
    localparam logic [15:0]     HOLDOFF_L    = 16'(HOLDOFF_US);
    localparam logic [15:0]     TIMEOUT_L    = 16'(TIMEOUT_US);
    localparam logic [9:0]      MAX_CM_L     = 10'(MAX_CM);
    localparam logic [5:0]      CM_FACTOR    = 6'(US_PER_CM);

    state_t        r_state;
    logic          r_trigMeta;
    logic          r_trigSync;
    logic          r_trigPrev;
    logic [PW-1:0] r_presc;
    logic [15:0]   r_usCnt;
    logic [19:0]   r_trigCnt;
    logic [9:0]    r_distance;
    logic [15:0]   r_echoWidth;
    logic          r_echo;
    logic          r_busy;
    logic          r_trigErr;
    logic          r_outOfRange;

    logic          w_trigRise;
    logic          w_presWrap;
    logic          w_usDone;
    logic [15:0]   w_usTarget;
    logic [15:0]   w_product;
    logic          w_outOfRange;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trigMeta <= 1'b0;
            r_trigSync <= 1'b0;
            r_trigPrev <= 1'b0;
        end else begin
            r_trigMeta <= trig;
            r_trigSync <= r_trigMeta;
            r_trigPrev <= r_trigSync;
        end
    end

    assign w_trigRise   = r_trigSync & ~r_trigPrev;
    assign w_presWrap   = (r_presc == PRESC_MAX);
    assign w_product    = {6'd0, r_distance} * {10'd0, CM_FACTOR};
    assign w_outOfRange = (r_distance == 10'd0) || (r_distance > MAX_CM_L);

    always_comb begin
        w_usTarget = BURST_L;
        case (r_state)
            ECHO:    w_usTarget = r_echoWidth;
            HOLDOFF: w_usTarget = HOLDOFF_L;
            default: w_usTarget = BURST_L;
        endcase
    end

    assign w_usDone = w_presWrap && (r_usCnt == w_usTarget - 16'd1);

    // Timed states share one prescaler/us counter that restarts on every transition,
    // so each interval is an exact multiple of CLK_PER_US cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_presc      <= '0;
            r_usCnt      <= '0;
            r_trigCnt    <= '0;
            r_distance   <= '0;
            r_echoWidth  <= '0;
            r_echo       <= 1'b0;
            r_busy       <= 1'b0;
            r_trigErr    <= 1'b0;
            r_outOfRange <= 1'b0;
        end else begin
            r_trigErr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_trigRise) begin
                        r_distance <= distance_cm;
                        r_trigCnt  <= 20'd1;
                        r_presc    <= '0;
                        r_usCnt    <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= TRIG_HI;
                    end
                end
                TRIG_HI: begin
                    if (!r_trigSync) begin
                        r_presc <= '0;
                        r_usCnt <= '0;
                        if (r_trigCnt >= TRIG_MIN_CYC) begin
                            r_echoWidth  <= w_outOfRange ? TIMEOUT_L : w_product;
                            r_outOfRange <= w_outOfRange;
                            r_state      <= DELAY;
                        end else begin
                            r_trigErr <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= IDLE;
                        end
                    end else if (r_trigCnt != '1) begin
                        r_trigCnt <= r_trigCnt + 20'd1;
                    end
                end
                DELAY, ECHO, HOLDOFF: begin
                    if (!w_presWrap) begin
                        r_presc <= r_presc + 1'b1;
                    end else begin
                        r_presc <= '0;
                        if (!w_usDone) begin
                            r_usCnt <= r_usCnt + 16'd1;
                        end else begin
                            r_usCnt <= '0;
                            if (r_state == DELAY) begin
                                r_echo  <= 1'b1;
                                r_state <= ECHO;
                            end else if (r_state == ECHO) begin
                                r_echo       <= 1'b0;
                                r_outOfRange <= 1'b0;
                                r_state      <= HOLDOFF;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    r_echo  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign echo         = r_echo;
    assign busy         = r_busy;
    assign trig_err     = r_trigErr;
    assign out_of_range = r_outOfRange;

endmodule
